// File: rtl/latch_write_sched.sv
// latch_write_sched: shares one external level-sensitive latch bank between
// NREQ requesters. Each write is framed as SETUP -> PULSE -> HOLD so latch data
// is stable around the transparent window. Bank clears run as a one-cycle
// latch_rst pulse and take priority over pending writes. Every output is a
// flop loaded from the next-state decode, so no input reaches an output
// combinationally.
module latch_write_sched #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_wdata,
  input  logic                  i_clr,
  output logic                  o_latch_en,
  output logic                  o_latch_rst,
  output logic [WIDTH-1:0]      o_latch_d,
  output logic [NREQ-1:0]       o_gnt,
  output logic [NREQ-1:0]       o_done,
  output logic                  o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(EN_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_win;
  logic [CW-1:0]     r_cnt;
  logic              r_clr_pend;

  logic [WIDTH-1:0]  w_wdata_arr [NREQ];
  logic              w_found;
  logic [IW-1:0]     w_win_idx;
  logic [WIDTH-1:0]  w_win_data;
  logic [IW:0]       w_sum;
  logic [IW-1:0]     w_ptr_nxt;
  logic              w_clr_req;
  logic              w_start;
  logic              w_enter_clr;
  logic [IW-1:0]     w_sel;
  logic [NREQ-1:0]   w_onehot;
  logic              w_en_nxt;
  logic              w_rst_nxt;
  logic              w_busy_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [NREQ-1:0]   w_done_nxt;

  // Split the flat write-data bus into one slice per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_wdata_arr[g] = i_wdata[g*WIDTH +: WIDTH];
  end

  // A clear pulse seen this cycle counts as pending right away.
  assign w_clr_req = r_clr_pend | i_clr;

  // Round-robin search: first active request at or after the pointer, with wrap.
  always_comb begin
    w_found    = 1'b0;
    w_win_idx  = '0;
    w_win_data = '0;
    w_sum      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && i_req[w_sum[IW-1:0]]) begin
        w_found    = 1'b1;
        w_win_idx  = w_sum[IW-1:0];
        w_win_data = w_wdata_arr[w_sum[IW-1:0]];
      end else begin
        w_found = w_found;
      end
    end
    if (w_win_idx == IW'(NREQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win_idx + IW'(1);
    end
  end

  // Next-state decode and the next value of every registered output.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_enter_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_enter_clr = 1'b1;
        end else if (w_found) begin
          w_state_nxt = ST_SETUP;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: w_state_nxt = ST_IDLE;
      ST_SETUP: w_state_nxt = ST_PULSE;
      ST_PULSE: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_PULSE;
        end
      end
      ST_HOLD:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    // The winner is not registered yet in the cycle the write starts.
    if (w_start) begin
      w_sel = w_win_idx;
    end else begin
      w_sel = r_win;
    end
    w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
    w_en_nxt   = (w_state_nxt == ST_PULSE);
    w_rst_nxt  = (w_state_nxt == ST_CLEAR);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    if ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PULSE) ||
        (w_state_nxt == ST_HOLD)) begin
      w_gnt_nxt = w_onehot;
    end else begin
      w_gnt_nxt = '0;
    end
    if (w_state_nxt == ST_HOLD) begin
      w_done_nxt = w_onehot;
    end else begin
      w_done_nxt = '0;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Winner, pointer, pulse-width counter and sticky clear flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      if (w_start) begin
        r_win <= w_win_idx;
        r_ptr <= w_ptr_nxt;
      end else begin
        r_win <= r_win;
        r_ptr <= r_ptr;
      end
      if (r_state == ST_SETUP) begin
        r_cnt <= CW'(EN_CYCLES);
      end else if (r_state == ST_PULSE) begin
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_enter_clr) begin
        r_clr_pend <= 1'b0;
      end else begin
        r_clr_pend <= w_clr_req;
      end
    end
  end

  // Registered latch-bank and requester-facing outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_latch_en  <= 1'b0;
      o_latch_rst <= 1'b0;
      o_latch_d   <= '0;
      o_gnt       <= '0;
      o_done      <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_latch_en  <= w_en_nxt;
      o_latch_rst <= w_rst_nxt;
      o_gnt       <= w_gnt_nxt;
      o_done      <= w_done_nxt;
      o_busy      <= w_busy_nxt;
      if (w_start) begin
        o_latch_d <= w_win_data;
      end else begin
        o_latch_d <= o_latch_d;
      end
    end
  end

endmodule

// File: tb/tb_latch_write_sched.sv
// Bench for latch_write_sched (NREQ=4, WIDTH=8, EN_CYCLES=2). A transaction
// model expands each accepted write or clear into the expected per-cycle output
// frames; a compare process checks the DUT against it every cycle, and the
// directed sequence adds literal checks at the interesting cycles.
module tb_latch_write_sched;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int ENC = 2;

  typedef struct packed {
    logic       en;
    logic       rst;
    logic [7:0] d;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] wdata = 32'h0000_0000;
  logic        clr = 1'b0;
  logic        latch_en;
  logic        latch_rst;
  logic [7:0]  latch_d;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  exp_t       m_q[$];
  exp_t       m_cur = '0;
  logic       m_idle = 1'b1;
  logic       m_pend = 1'b0;
  int         m_ptr = 0;
  logic [7:0] m_d = 8'h00;

  latch_write_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .EN_CYCLES(ENC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wdata(wdata), .i_clr(clr),
    .o_latch_en(latch_en), .o_latch_rst(latch_rst), .o_latch_d(latch_d),
    .o_gnt(gnt), .o_done(done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic en, input logic rs, input logic [7:0] d,
                              input logic [3:0] g, input logic [3:0] dn, input logic b);
    exp_t e;
    e.en = en; e.rst = rs; e.d = d; e.gnt = g; e.done = dn; e.busy = b;
    return e;
  endfunction

  // Transaction model: on an idle cycle decide clear / write / nothing, then
  // queue the frames that operation must produce in the following cycles.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_idle = 1'b1; m_pend = 1'b0; m_ptr = 0; m_d = 8'h00;
        m_cur = '0;
      end else begin
        m_pend = m_pend | clr;
        if (m_idle) begin
          if (m_pend) begin
            m_q.push_back(mk(1'b0, 1'b1, m_d, 4'b0000, 4'b0000, 1'b1));
            m_pend = 1'b0;
          end else if (req != 4'b0000) begin
            int w;
            logic [3:0] g;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
              if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            m_d = wdata[w*WIDTH +: WIDTH];
            m_ptr = (w + 1) % NREQ;
            g = 4'b0001 << w;
            m_q.push_back(mk(1'b0, 1'b0, m_d, g, 4'b0000, 1'b1));
            for (int k = 0; k < ENC; k++) m_q.push_back(mk(1'b1, 1'b0, m_d, g, 4'b0000, 1'b1));
            m_q.push_back(mk(1'b0, 1'b0, m_d, g, g, 1'b1));
          end
        end
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_idle = 1'b0;
        end else begin
          m_cur = mk(1'b0, 1'b0, m_d, 4'b0000, 4'b0000, 1'b0);
          m_idle = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("cycle_frame", {13'd0, latch_en, latch_rst, latch_d, gnt, done, busy}, {13'd0, m_cur});
      chk("en_rst_excl", {31'd0, latch_en & latch_rst}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1);
  end

  // Directed sequence. Inputs change on negedges; "cycle 0" is the cycle in
  // which new inputs are first sampled.
  initial begin
    // Reset release, idle for 10 cycles.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {13'd0, latch_en, latch_rst, latch_d, gnt, done, busy}, 32'd0);
    end

    // Single write by requester 2.
    req = 4'b0100; wdata = 32'h00A5_0000;
    @(negedge clk);
    chk("wr_setup_gnt", {28'd0, gnt}, 32'h4);
    chk("wr_setup_d", {24'd0, latch_d}, 32'hA5);
    chk("wr_setup_en", {31'd0, latch_en}, 32'd0);
    @(negedge clk); chk("wr_pulse1_en", {31'd0, latch_en}, 32'd1);
    @(negedge clk); chk("wr_pulse2_en", {31'd0, latch_en}, 32'd1);
    @(negedge clk);
    chk("wr_hold_done", {28'd0, done}, 32'h4);
    chk("wr_hold_en", {31'd0, latch_en}, 32'd0);
    req = 4'b0000;
    @(negedge clk); chk("wr_idle_busy", {31'd0, busy}, 32'd0);

    // Fairness from a fresh pointer: grants 0,1,2,3,0 five cycles apart.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111; wdata = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] eg;
      logic [7:0] ed;
      eg = 4'b0001 << (i % 4);
      ed = wdata[(i % 4)*8 +: 8];
      @(negedge clk);
      chk("rr_gnt", {28'd0, gnt}, {28'd0, eg});
      chk("rr_data", {24'd0, latch_d}, {24'd0, ed});
      if (i == 4) req = 4'b0000;
      repeat (4) @(negedge clk);
    end

    // Clear and req[1] in the same idle cycle: clear runs first.
    clr = 1'b1; req = 4'b0010; wdata = 32'h0000_5A00;
    @(negedge clk);
    clr = 1'b0;
    chk("clrpri_rst", {31'd0, latch_rst}, 32'd1);
    chk("clrpri_en", {31'd0, latch_en}, 32'd0);
    @(negedge clk);
    chk("clrpri_rst_off", {31'd0, latch_rst}, 32'd0);
    chk("clrpri_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("clrpri_gnt", {28'd0, gnt}, 32'h2);
    chk("clrpri_d", {24'd0, latch_d}, 32'h5A);
    repeat (3) @(negedge clk);
    chk("clrpri_done", {28'd0, done}, 32'h2);
    req = 4'b0000;
    @(negedge clk);

    // Clear arriving during requester 0's pulse; requester 3 pending.
    req = 4'b0001; wdata = 32'hC300_003C;
    @(negedge clk);
    chk("clrmid_gnt0", {28'd0, gnt}, 32'h1);
    req = 4'b1001;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("clrmid_done0", {28'd0, done}, 32'h1);
    req = 4'b1000;
    @(negedge clk);
    chk("clrmid_idle_rst", {31'd0, latch_rst}, 32'd0);
    chk("clrmid_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("clrmid_rst", {31'd0, latch_rst}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("clrmid_gnt3", {28'd0, gnt}, 32'h8);
    chk("clrmid_d3", {24'd0, latch_d}, 32'hC3);

    // Data stability: wdata changes and req[3] drops during the pulse.
    @(negedge clk);
    wdata = 32'hFF00_0000; req = 4'b0000;
    @(negedge clk);
    chk("stab_pulse_d", {24'd0, latch_d}, 32'hC3);
    @(negedge clk);
    chk("stab_hold_done", {28'd0, done}, 32'h8);
    chk("stab_hold_d", {24'd0, latch_d}, 32'hC3);
    @(negedge clk);
    chk("stab_idle_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a pulse.
    req = 4'b0100; wdata = 32'h0077_0000;
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_en", {31'd0, latch_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_en", {31'd0, latch_en}, 32'd0);
    chk("arst_gnt", {28'd0, gnt}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_d", {24'd0, latch_d}, 32'd0);
    @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_done", {28'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/latch_write_sched.md
# latch_write_sched

Sequencer and round-robin arbiter that shares one external WIDTH-bit level-sensitive D-latch bank (enable, reset, data, q) between NREQ requesters. It generates setup/enable/hold timing for each write so the latch data is stable before, during and after the transparent window. It also issues bank-clear pulses on the latch reset input. It sits between requesting agents and the latch bank, and is the only driver of the latch control pins.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, latch bank data width
- EN_CYCLES, 2, cycles latch_en stays high per write (>=1)

- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  write request per requester; level, held until matching done
- wdata  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
- clr  in  1  bank-clear request, single-cycle pulse or level
- latch_en  out  1  latch enable to bank
- latch_rst  out  1  latch reset to bank, active-high
- latch_d  out  WIDTH  latch data to bank
- gnt  out  NREQ  one-hot grant, held for the whole write
- done  out  NREQ  one-cycle completion pulse, one-hot
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CLEAR, SETUP, PULSE, HOLD.
- IDLE:
  - If clr_pend is set, go to CLEAR.
  - Else if any req bit is high, pick a winner round-robin, register its wdata into latch_d, and go to SETUP.
  - Else stay in IDLE.
- clr_pend is a sticky flag. It sets on any cycle with clr=1, including during a write, and clears on entry to CLEAR. Clear has priority over all writes.
- CLEAR: 1 cycle; latch_rst=1, latch_en=0. Then IDLE. No done is generated.
- SETUP: 1 cycle; gnt[w]=1, latch_d stable, latch_en=0.
- PULSE: EN_CYCLES cycles; latch_en=1. A down-counter of width $clog2(EN_CYCLES+1) times it.
- HOLD: 1 cycle; latch_en=0, latch_d unchanged, done[w]=1. Then IDLE.
- gnt[w] stays high from SETUP through HOLD.
- latch_d is captured once on leaving IDLE. It does not change until the next capture, so wdata changes during a write are ignored.
- Round robin:
  - The pointer starts at requester 0.
  - After a grant to w, the pointer moves to (w+1) mod NREQ.
  - The search starts at the pointer, ascending with wrap.
- Dropping req mid-write does not abort it; the write completes and done still pulses.
- A requester whose req is still high in the IDLE cycle after its done is treated as a new request. Round robin then favours other requesters.
- latch_en and latch_rst are never high together. latch_en is never high in SETUP, HOLD, IDLE or CLEAR.

## Timing
- Reset: state=IDLE, pointer=0, clr_pend=0, latch_en=0, latch_rst=0, latch_d=0, gnt=0, done=0, busy=0.
- Reset acts asynchronously, including mid-write, and all outputs go to reset values immediately. No done is issued for the aborted write.
- All outputs are registered (direct state decode from flops, no combinational path from inputs).
- Write timeline, with req seen in IDLE at cycle 0:
  - Cycle 1: SETUP (gnt high).
  - Cycles 2..1+EN_CYCLES: PULSE.
  - Cycle 2+EN_CYCLES: HOLD (done high).
  - Cycle 3+EN_CYCLES: IDLE.
- Back-to-back writes take 3+EN_CYCLES cycles each, since one IDLE cycle is required between transactions.
- Clear: clr seen in IDLE at cycle 0 gives latch_rst=1 in cycle 1 and IDLE in cycle 2.
- clr and req high together in IDLE: CLEAR runs first, and the write starts from the following IDLE.
- clr during a write: the write finishes, then CLEAR runs, then pending requests are served.

## Test plan
- Reset release with no requests, EN_CYCLES=2: all outputs 0 and busy=0 for 10 cycles; assert rst low mid-PULSE and check latch_en drops to 0 the same instant.
- Single write, req[2]=1, wdata slice 2 = 8'hA5:
  - Cycle 1: gnt=4'b0100, latch_d=A5, latch_en=0.
  - Cycles 2-3: latch_en=1.
  - Cycle 4: done=4'b0100, latch_en=0.
  - Cycle 5: busy=0.
- Fairness: req=4'b1111 held continuously; grants follow 0,1,2,3,0, each 5 cycles apart; latch_d matches each winner's slice.
- Clear priority: clr and req[1] both pulsed in the same IDLE cycle; latch_rst=1 for exactly one cycle, then gnt=4'b0010 two cycles after clr; latch_en and latch_rst never high together.
- Clr mid-write: clr pulsed during PULSE of requester 0; done[0] still pulses, latch_rst=1 in the cycle after the following IDLE, then other pending req served.
- Data stability: change wdata and drop req[3] during PULSE of requester 3; latch_d holds the original value through HOLD and done[3] still fires.
